// File: rtl/font_arb_pkg.sv
// Shared types for the font ROM arbiter: port identifiers, the in-flight read tag
// and the default font ROM geometry.
package font_arb_pkg;

   localparam int FONT_ADDR_W = 11;
   localparam int FONT_DATA_W = 8;

   typedef enum logic {
      PORT_TEXT   = 1'b0,
      PORT_STATUS = 1'b1
   } port_e;

   typedef struct packed {
      logic  valid;
      port_e port;
   } tag_t;

   localparam tag_t TAG_NONE = '{valid: 1'b0, port: PORT_TEXT};

endpackage

// File: rtl/font_arb_tag_pipe.sv
// Tag shift register that follows each ROM read from grant to returned data.
// The next-to-last stage enables data capture; the last stage drives the valid strobes.
module font_arb_tag_pipe
   import font_arb_pkg::*;
#(
   parameter int ROM_LAT = 1
)
(
   input  logic i_clk,
   input  logic i_rst,
   input  tag_t i_tag,
   output logic o_cap0,
   output logic o_cap1,
   output logic o_vld0,
   output logic o_vld1
);

   tag_t [ROM_LAT:0] r_pipe;
   tag_t             w_capTag;
   tag_t             w_outTag;

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_pipe <= '0;
      end else begin
         r_pipe <= {r_pipe[ROM_LAT-1:0], i_tag};
      end
   end

   // ROM data for a tag is on the bus while the tag sits one stage before the end
   assign w_capTag = r_pipe[ROM_LAT-1];
   assign w_outTag = r_pipe[ROM_LAT];

   assign o_cap0 = w_capTag.valid && (w_capTag.port == PORT_TEXT);
   assign o_cap1 = w_capTag.valid && (w_capTag.port == PORT_STATUS);
   assign o_vld0 = w_outTag.valid && (w_outTag.port == PORT_TEXT);
   assign o_vld1 = w_outTag.valid && (w_outTag.port == PORT_STATUS);

endmodule

// File: rtl/font_rom_arbiter.sv
// Two-port arbiter for the shared font ROM: text renderer has priority in active video,
// round-robin in blanking. Define FONT_ARB_STARVE_FORCE_EN to let a starved port 1 force a grant.
module font_rom_arbiter
   import font_arb_pkg::*;
#(
   parameter int ADDR_W     = FONT_ADDR_W,
   parameter int DATA_W     = FONT_DATA_W,
   parameter int ROM_LAT    = 1,
   parameter int STARVE_MAX = 15
)
(
   input  logic              pixel_clk,
   input  logic              rst,
   input  logic              blank,
   input  logic              req0,
   input  logic [ADDR_W-1:0] addr0,
   output logic              gnt0,
   output logic              vld0,
   output logic [DATA_W-1:0] data0,
   input  logic              req1,
   input  logic [ADDR_W-1:0] addr1,
   output logic              gnt1,
   output logic              vld1,
   output logic [DATA_W-1:0] data1,
   output logic [ADDR_W-1:0] rom_addr,
   input  logic [DATA_W-1:0] rom_data,
   output logic              starve_err
);

   localparam logic [7:0] STARVE_LIM = 8'(STARVE_MAX);

   port_e             r_rrLast;
   logic [7:0]        r_starveCnt;
   logic              r_starveErr;
   logic [ADDR_W-1:0] r_romAddr;
   logic [DATA_W-1:0] r_data0;
   logic [DATA_W-1:0] r_data1;

   logic              w_force;
   logic              w_anyGnt;
   port_e             w_winPort;
   logic [7:0]        w_starveNext;
   tag_t              w_tag;
   logic              w_cap0;
   logic              w_cap1;

`ifdef FONT_ARB_STARVE_FORCE_EN
   assign w_force = req1 && (r_starveCnt == STARVE_LIM);
`else
   assign w_force = 1'b0;
`endif

   always_comb begin
      gnt0 = 1'b0;
      gnt1 = 1'b0;
      if (w_force) begin
         gnt1 = 1'b1;
      end else if (!blank) begin
         gnt0 = req0;
         gnt1 = req1 && !req0;
      end else if (req0 && req1) begin
         // Round-robin: the port that did not win last time goes first
         if (r_rrLast == PORT_STATUS) begin
            gnt0 = 1'b1;
         end else begin
            gnt1 = 1'b1;
         end
      end else begin
         gnt0 = req0;
         gnt1 = req1;
      end
   end

   assign w_anyGnt  = gnt0 || gnt1;
   assign w_winPort = gnt1 ? PORT_STATUS : PORT_TEXT;
   assign w_tag     = '{valid: w_anyGnt, port: w_winPort};

   assign w_starveNext = (req1 && !gnt1)
                       ? ((r_starveCnt == STARVE_LIM) ? STARVE_LIM : r_starveCnt + 8'd1)
                       : 8'd0;

   always_ff @(posedge pixel_clk or posedge rst) begin
      if (rst) begin
         r_rrLast    <= PORT_STATUS;
         r_romAddr   <= '0;
         r_starveCnt <= 8'd0;
         r_starveErr <= 1'b0;
      end else begin
         if (w_anyGnt) begin
            r_rrLast  <= w_winPort;
            r_romAddr <= gnt1 ? addr1 : addr0;
         end
         r_starveCnt <= w_starveNext;
         if (w_starveNext == STARVE_LIM) begin
            r_starveErr <= 1'b1;
         end
      end
   end

   always_ff @(posedge pixel_clk or posedge rst) begin
      if (rst) begin
         r_data0 <= '0;
         r_data1 <= '0;
      end else begin
         if (w_cap0) begin
            r_data0 <= rom_data;
         end
         if (w_cap1) begin
            r_data1 <= rom_data;
         end
      end
   end

   font_arb_tag_pipe #(
      .ROM_LAT (ROM_LAT)
   ) u_tagPipe (
      .i_clk  (pixel_clk),
      .i_rst  (rst),
      .i_tag  (w_tag),
      .o_cap0 (w_cap0),
      .o_cap1 (w_cap1),
      .o_vld0 (vld0),
      .o_vld1 (vld1)
   );

   assign rom_addr   = r_romAddr;
   assign data0      = r_data0;
   assign data1      = r_data1;
   assign starve_err = r_starveErr;

endmodule

// File: tb/tb_font_rom_arbiter.sv
// Self-checking bench for font_rom_arbiter: vector table, directed corner cases and
// random traffic against a transaction-level model (queue of reads due at future cycles).
module tb_font_rom_arbiter;
   import font_arb_pkg::*;

   localparam int ADDR_W     = 11;
   localparam int DATA_W     = 8;
   localparam int ROM_LAT    = 1;
   localparam int STARVE_MAX = 15;

   logic              pixel_clk = 1'b0;
   logic              rst = 1'b1;
   logic              blank = 1'b0;
   logic              req0 = 1'b0;
   logic              req1 = 1'b0;
   logic [ADDR_W-1:0] addr0 = '0;
   logic [ADDR_W-1:0] addr1 = '0;
   logic              gnt0, gnt1, vld0, vld1, starve_err;
   logic [DATA_W-1:0] data0, data1, rom_data;
   logic [ADDR_W-1:0] rom_addr;

   int checks = 0;
   int failures = 0;

   typedef struct {
      int               due;
      bit               port;
      logic [ADDR_W-1:0] addr;
   } pend_t;

   typedef struct {
      bit               b;
      bit               r0;
      logic [ADDR_W-1:0] a0;
      bit               r1;
      logic [ADDR_W-1:0] a1;
      bit               g0;
      bit               g1;
   } vec_t;

   pend_t             pend[$];
   bit                mRrLast;
   int                mStarve;
   bit                mErr;
   logic [ADDR_W-1:0] mRomAddr;
   logic [DATA_W-1:0] mData0, mData1;
   int                cyc;
   bit                lastG0, lastG1;
   int                vld0Seen, vld1Seen;
   vec_t              vecs[10];

   always #5 pixel_clk = ~pixel_clk;

   function automatic logic [DATA_W-1:0] romFn(input logic [ADDR_W-1:0] a);
      return a[7:0] ^ {a[10:8], a[4:0]} ^ 8'h5A;
   endfunction

   // ROM with one cycle from the registered address to data
   assign rom_data = romFn(rom_addr);

   font_rom_arbiter #(
      .ADDR_W     (ADDR_W),
      .DATA_W     (DATA_W),
      .ROM_LAT    (ROM_LAT),
      .STARVE_MAX (STARVE_MAX)
   ) dut (
      .pixel_clk  (pixel_clk),
      .rst        (rst),
      .blank      (blank),
      .req0       (req0),
      .addr0      (addr0),
      .gnt0       (gnt0),
      .vld0       (vld0),
      .data0      (data0),
      .req1       (req1),
      .addr1      (addr1),
      .gnt1       (gnt1),
      .vld1       (vld1),
      .data1      (data1),
      .rom_addr   (rom_addr),
      .rom_data   (rom_data),
      .starve_err (starve_err)
   );

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // One clock: drive inputs, check grants against the model, then check registered outputs
   task automatic applyStimulus(input bit b, input bit r0, input logic [ADDR_W-1:0] a0,
                                input bit r1, input logic [ADDR_W-1:0] a1);
      bit    e0, e1, forceWin, ev0, ev1;
      pend_t p;
      blank = b; req0 = r0; addr0 = a0; req1 = r1; addr1 = a1;
      #2;
      e0 = 1'b0;
      e1 = 1'b0;
`ifdef FONT_ARB_STARVE_FORCE_EN
      forceWin = r1 && (mStarve >= STARVE_MAX);
`else
      forceWin = 1'b0;
`endif
      if (forceWin) e1 = 1'b1;
      else if (r0 && r1) begin
         if (!b || mRrLast) e0 = 1'b1;
         else e1 = 1'b1;
      end else begin
         e0 = r0;
         e1 = r1;
      end
      checkOutput("gnt0", gnt0, e0);
      checkOutput("gnt1", gnt1, e1);
      lastG0 = gnt0;
      lastG1 = gnt1;
      if (r1 && !e1) mStarve = (mStarve < STARVE_MAX) ? mStarve + 1 : STARVE_MAX;
      else mStarve = 0;
      if (mStarve == STARVE_MAX) mErr = 1'b1;
      if (e0 || e1) begin
         mRrLast  = e1;
         mRomAddr = e1 ? a1 : a0;
         pend.push_back('{cyc + 1 + ROM_LAT, e1, mRomAddr});
      end
      @(posedge pixel_clk);
      #1;
      cyc++;
      ev0 = 1'b0;
      ev1 = 1'b0;
      while (pend.size() > 0 && pend[0].due == cyc) begin
         p = pend.pop_front();
         if (p.port) begin
            ev1 = 1'b1;
            mData1 = romFn(p.addr);
         end else begin
            ev0 = 1'b1;
            mData0 = romFn(p.addr);
         end
      end
      checkOutput("vld0", vld0, ev0);
      checkOutput("vld1", vld1, ev1);
      checkOutput("data0", data0, mData0);
      checkOutput("data1", data1, mData1);
      checkOutput("rom_addr", rom_addr, mRomAddr);
      checkOutput("starve_err", starve_err, mErr);
      vld0Seen += int'(vld0);
      vld1Seen += int'(vld1);
   endtask

   task automatic doReset();
      rst = 1'b1;
      blank = 1'b0; req0 = 1'b0; req1 = 1'b0; addr0 = '0; addr1 = '0;
      #1;
      checkOutput("rst vld0", vld0, 0);
      checkOutput("rst vld1", vld1, 0);
      checkOutput("rst rom_addr", rom_addr, 0);
      checkOutput("rst starve_err", starve_err, 0);
      checkOutput("rst data0", data0, 0);
      @(posedge pixel_clk);
      @(posedge pixel_clk);
      #1;
      rst = 1'b0;
      pend.delete();
      mRrLast = 1'b1; mStarve = 0; mErr = 1'b0; mRomAddr = '0;
      mData0 = '0; mData1 = '0; cyc = 0;
   endtask

   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      vecs[0] = '{0, 1, 11'h0B3, 0, 11'h000, 1, 0};
      vecs[1] = '{0, 0, 11'h000, 1, 11'h401, 0, 1};
      vecs[2] = '{0, 1, 11'h010, 1, 11'h402, 1, 0};
      vecs[3] = '{1, 1, 11'h011, 1, 11'h403, 0, 1};
      vecs[4] = '{1, 1, 11'h012, 1, 11'h404, 1, 0};
      vecs[5] = '{1, 1, 11'h013, 0, 11'h000, 1, 0};
      vecs[6] = '{1, 1, 11'h014, 1, 11'h405, 0, 1};
      vecs[7] = '{0, 0, 11'h000, 0, 11'h000, 0, 0};
      vecs[8] = '{1, 0, 11'h000, 1, 11'h406, 0, 1};
      vecs[9] = '{1, 1, 11'h015, 1, 11'h407, 1, 0};

      doReset();
      for (int i = 0; i < 10; i++) begin
         applyStimulus(vecs[i].b, vecs[i].r0, vecs[i].a0, vecs[i].r1, vecs[i].a1);
         checkOutput($sformatf("vec%0d gnt0", i), lastG0, vecs[i].g0);
         checkOutput($sformatf("vec%0d gnt1", i), lastG1, vecs[i].g1);
      end
      for (int i = 0; i < 3; i++) applyStimulus(0, 0, 0, 0, 0);

      // Single read: address next cycle, data two cycles after grant
      doReset();
      applyStimulus(0, 1, 11'h0B3, 0, 0);
      checkOutput("single gnt0", lastG0, 1);
      checkOutput("single rom_addr", rom_addr, 11'h0B3);
      applyStimulus(0, 0, 0, 0, 0);
      checkOutput("single vld0", vld0, 1);
      checkOutput("single data0", data0, romFn(11'h0B3));

      // Active video priority
      vld0Seen = 0; vld1Seen = 0;
      for (int i = 0; i < 10; i++) applyStimulus(0, 1, 11'(16 + i), 1, 11'h7F0);
      for (int i = 0; i < 3; i++) applyStimulus(0, 0, 0, 0, 0);
      checkOutput("prio vld0 count", vld0Seen, 10);
      checkOutput("prio vld1 count", vld1Seen, 0);

      // Blanking round-robin, then blank edge with rr_last on port 0
      doReset();
      for (int i = 0; i < 6; i++) begin
         applyStimulus(1, 1, 11'(32 + i), 1, 11'(1024 + i));
         checkOutput("rr gnt1", lastG1, i % 2);
      end
      applyStimulus(0, 1, 11'h050, 1, 11'h450);
      applyStimulus(0, 1, 11'h051, 1, 11'h451);
      applyStimulus(1, 1, 11'h052, 1, 11'h452);
      checkOutput("blank edge gnt1", lastG1, 1);
      for (int i = 0; i < 3; i++) applyStimulus(0, 0, 0, 0, 0);

      // Starvation
      doReset();
      for (int i = 1; i <= 20; i++) begin
         applyStimulus(0, 1, 11'(i), 1, 11'(1792 + i));
         if (i == 14) checkOutput("starve pre", starve_err, 0);
         if (i == 15) checkOutput("starve set", starve_err, 1);
`ifdef FONT_ARB_STARVE_FORCE_EN
         if (i == 16) checkOutput("force gnt1", lastG1, 1);
`else
         if (i == 16) checkOutput("no force gnt1", lastG1, 0);
`endif
      end
      for (int i = 0; i < 3; i++) applyStimulus(1, 0, 0, 0, 0);
      checkOutput("starve sticky", starve_err, 1);

      // Reset with reads in flight
      applyStimulus(0, 1, 11'h123, 0, 0);
      doReset();
      vld0Seen = 0; vld1Seen = 0;
      for (int i = 0; i < 4; i++) applyStimulus(0, 0, 0, 0, 0);
      checkOutput("post-rst vld count", vld0Seen + vld1Seen, 0);
      checkOutput("post-rst rom_addr", rom_addr, 0);

      // Random traffic
      for (int i = 0; i < 400; i++) begin
         applyStimulus($urandom_range(0, 2) == 0, 1'($urandom_range(0, 1)), 11'($urandom),
                       1'($urandom_range(0, 1)), 11'($urandom));
      end
      for (int i = 0; i < 3; i++) applyStimulus(0, 0, 0, 0, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/font_rom_arbiter.md
Name: font_rom_arbiter

Overview:
- Shares the single synchronous font ROM between two requesters in the pixel-clock domain.
- Port 0 is the on-screen text renderer and is latency-critical during active video. Port 1 is the status/banner renderer (sensor-level messages), which is only served freely during blanking.
- Issues one ROM address per cycle, tracks in-flight reads and routes returned font rows to the owner with a valid strobe. Also flags starvation of port 1.

Parameters:
- ADDR_W, 11, font ROM address width ({char[6:0], row[3:0]})
- DATA_W, 8, font row width
- ROM_LAT, 1, cycles from rom_addr registered to rom_data valid (1..4)
- STARVE_MAX, 15, consecutive ungranted req1 cycles before starvation is declared (1..255)

Ports:
- pixel_clk  in  1  pixel clock (25 MHz)
- rst  in  1  asynchronous, active-high reset
- blank  in  1  1 = horizontal/vertical blanking from the VGA timing controller
- req0  in  1  port 0 read request
- addr0  in  ADDR_W  port 0 address; held stable while req0=1 and gnt0=0
- gnt0  out  1  port 0 request accepted this cycle
- vld0  out  1  data0 valid
- data0  out  DATA_W  font row for port 0
- req1, addr1, gnt1, vld1, data1  same as port 0, for port 1
- rom_addr  out  ADDR_W  registered address to font ROM
- rom_data  in  DATA_W  font ROM output
- starve_err  out  1  sticky: port 1 starvation occurred

Behaviour:
- Reset (async assert, sync release): rom_addr=0, gnt0=gnt1=0, vld0=vld1=0, data0=data1=0, starve_err=0, rr_last=1, starve_cnt=0, in-flight tag pipeline cleared.
- Reset mid-read discards all in-flight reads; no vld is issued for them after release.
- Grants are combinational from req0/req1/blank/state. At most one gnt per cycle; gnt is never asserted without the matching req.
- Active video (blank=0): fixed priority, port 0 wins. gnt1 only when req0=0.
- Blanking (blank=1): round-robin.
  - If both request, grant the port not in rr_last.
  - rr_last updates on every grant, in both modes.
- On a grant in cycle N:
  - rom_addr <= winner's address at the end of N.
  - A tag {valid, port} enters a ROM_LAT+1 deep shift register.
- In cycle N+1+ROM_LAT: vldX=1 for exactly one cycle and dataX=rom_data registered.
  - Total grant-to-vld latency is ROM_LAT+1 cycles; the ROM_LAT=1 default gives 2.
- Throughput: one read per cycle sustained. Back-to-back grants to the same port are allowed (req held high, new addr each granted cycle).
- With no grant, rom_addr holds its last value and an invalid tag is shifted in.
- starve_cnt (8 bit):
  - increments each cycle with req1=1 and gnt1=0;
  - clears on gnt1 or req1=0;
  - saturates at STARVE_MAX.
  - When it reaches STARVE_MAX, starve_err is set and stays set until rst.
- A blank edge coincident with requests: the arbitration mode is taken from blank in the same cycle; no extra delay.
- Requester deasserting req before gnt is legal (request withdrawn, nothing issued).

Optional Feature:
- Macro: FONT_ARB_STARVE_FORCE_EN.
- Defined: when starve_cnt==STARVE_MAX and req1=1, port 1 wins the next arbitration even during active video (gnt0=0 that cycle); starve_cnt clears; starve_err is still set.
- Undefined: port 0 priority in active video is absolute; starvation only sets starve_err.

Decomposition:
- Shared package font_arb_pkg:
  - FONT_ADDR_W=11, FONT_DATA_W=8;
  - port id constants PORT_TEXT=0, PORT_STATUS=1;
  - tag record type {valid, port}.
- One natural sub-module: font_arb_tag_pipe. It is a parameterised ROM_LAT+1 deep tag shift register with reset clear, and produces vld0/vld1 and the data capture enable.

Test Plan:
- Reset/idle: rst pulse mid-run with reads in flight -> after release no vld0/vld1 for 4 cycles; rom_addr=0, starve_err=0.
- Single read: blank=0, req0 with addr0=11'h0B3 for one cycle -> gnt0 same cycle; rom_addr=0x0B3 next cycle; vld0 2 cycles after grant with data0=ROM[0x0B3].
- Active priority: blank=0, req0 and req1 held 10 cycles -> gnt0 every cycle, gnt1 never; 10 vld0 pulses, none on vld1.
- Blanking round-robin: blank=1, both held 6 cycles after reset -> grants 0,1,0,1,0,1; the data order matches the addresses.
- Starvation: blank=0, req0 and req1 held 20 cycles, STARVE_MAX=15 -> starve_err rises on the 15th ungranted cycle and stays 1 after blank=1. With FONT_ARB_STARVE_FORCE_EN, gnt1 is asserted on cycle 16.
- Blank edge: blank 0->1 while both request with rr_last=0 -> first blanking cycle grants port 1.
